// File: rtl/freepdk45_sram_1w1r_param.sv
// One-write/one-read synchronous SRAM model with per-lane write mask and a selectable 1- or 2-cycle read latency.
// Define SRAM_RW_FORWARD_EN to forward same-edge write data into a colliding read; otherwise the pre-write word is returned.
module freepdk45_sram_1w1r_param #(
  parameter int DATA_WIDTH   = 52,
  parameter int WRITE_SIZE   = 13,
  parameter int ADDR_WIDTH   = 7,
  parameter int RAM_DEPTH    = 128,
  parameter int READ_LATENCY = 1,
  localparam int NUM_WMASKS  = DATA_WIDTH / WRITE_SIZE
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  addr_err,
  output logic [15:0]           coll_cnt
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [RAM_DEPTH];

  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic                  wr_in_range_s;
  logic                  rd_in_range_s;
  logic                  coll_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  logic [DATA_WIDTH-1:0] s1_data_r;
  logic                  s1_valid_r;
  logic [DATA_WIDTH-1:0] dout_r;
  logic                  dout_valid_r;
  logic                  addr_err_r;
  logic [15:0]           coll_cnt_r;

  // Replace the lanes of old_word selected by mask with the matching lanes of new_word.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NUM_WMASKS-1:0] mask
  );
    logic [DATA_WIDTH-1:0] word_v;
    word_v = old_word;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (mask[i]) begin
        word_v[i*WRITE_SIZE +: WRITE_SIZE] = new_word[i*WRITE_SIZE +: WRITE_SIZE];
      end else begin
        word_v[i*WRITE_SIZE +: WRITE_SIZE] = old_word[i*WRITE_SIZE +: WRITE_SIZE];
      end
    end
    return word_v;
  endfunction

  assign wr_acc_s      = !csb0 && !rst0;
  assign rd_acc_s      = !csb1 && !rst0;
  assign wr_in_range_s = {1'b0, addr0} < DEPTH_L;
  assign rd_in_range_s = {1'b0, addr1} < DEPTH_L;
  assign coll_s        = wr_acc_s && rd_acc_s && wr_in_range_s && (addr0 == addr1);

  // Read word selection: out-of-range reads return zero.
  always_comb begin
    rd_word_s = '0;
    if (rd_in_range_s) begin
`ifdef SRAM_RW_FORWARD_EN
      rd_word_s = coll_s ? merge_lanes(mem_r[addr1], din0, wmask0) : mem_r[addr1];
`else
      rd_word_s = mem_r[addr1];
`endif
    end else begin
      rd_word_s = '0;
    end
  end

  // Memory array write; contents are intentionally never reset.
  always_ff @(posedge clk0) begin
    if (wr_acc_s && wr_in_range_s) begin
      mem_r[addr0] <= merge_lanes(mem_r[addr0], din0, wmask0);
    end
  end

  // First read stage: captures the word on the accepting edge.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      s1_data_r  <= '0;
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= rd_acc_s;
      if (rd_acc_s) begin
        s1_data_r <= rd_word_s;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      // Extra output register; a reset drops whatever is in flight.
      always_ff @(posedge clk0) begin
        if (rst0) begin
          dout_r       <= '0;
          dout_valid_r <= 1'b0;
        end else begin
          dout_valid_r <= s1_valid_r;
          if (s1_valid_r) begin
            dout_r <= s1_data_r;
          end
        end
      end
    end else begin : g_lat1
      assign dout_r       = s1_data_r;
      assign dout_valid_r = s1_valid_r;
    end
  endgenerate

  // Sticky range error and saturating collision counter.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      addr_err_r <= 1'b0;
      coll_cnt_r <= 16'd0;
    end else begin
      if ((wr_acc_s && !wr_in_range_s) || (rd_acc_s && !rd_in_range_s)) begin
        addr_err_r <= 1'b1;
      end
      if (coll_s && (coll_cnt_r != 16'hFFFF)) begin
        coll_cnt_r <= coll_cnt_r + 16'd1;
      end
    end
  end

  assign dout1       = dout_r;
  assign dout1_valid = dout_valid_r;
  assign addr_err    = addr_err_r;
  assign coll_cnt    = coll_cnt_r;

endmodule

// File: tb/tb_freepdk45_sram_1w1r_param.sv
// Randomised self-checking bench: latency-1 and latency-2 instances (depth 100) share stimulus against a word-level model.
// Expected collision data follows SRAM_RW_FORWARD_EN when it is defined for the build.
module tb_freepdk45_sram_1w1r_param;

  logic        clk0;
  logic        rst0;
  logic        csb0;
  logic [3:0]  wmask0;
  logic [6:0]  addr0;
  logic [51:0] din0;
  logic        csb1;
  logic [6:0]  addr1;

  logic [51:0] d1_dout, d2_dout;
  logic        d1_valid, d2_valid, d1_err, d2_err;
  logic [15:0] d1_cnt, d2_cnt;

  // model state
  logic [51:0] m_mem [100];
  logic        m_err;
  int          m_cnt;
  logic [51:0] e1_d, e2_d, p_d;
  logic        e1_v, e2_v, p_v;

  int n_checks;
  int n_fail;

  freepdk45_sram_1w1r_param #(.RAM_DEPTH(100), .READ_LATENCY(1)) u_l1 (
    .clk0(clk0), .rst0(rst0), .csb0(csb0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .csb1(csb1), .addr1(addr1), .dout1(d1_dout), .dout1_valid(d1_valid),
    .addr_err(d1_err), .coll_cnt(d1_cnt)
  );

  freepdk45_sram_1w1r_param #(.RAM_DEPTH(100), .READ_LATENCY(2)) u_l2 (
    .clk0(clk0), .rst0(rst0), .csb0(csb0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .csb1(csb1), .addr1(addr1), .dout1(d2_dout), .dout1_valid(d2_valid),
    .addr_err(d2_err), .coll_cnt(d2_cnt)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  // Advance the model by one edge using the current inputs, then let the DUTs take the edge.
  task automatic tick();
    logic [51:0] rd;
    logic [51:0] bm;
    bm = 52'd0;
    for (int i = 0; i < 4; i++) begin
      if (wmask0[i]) bm[i*13 +: 13] = 13'h1FFF;
    end
    if (rst0) begin
      e1_d = 52'd0; e1_v = 1'b0; e2_d = 52'd0; e2_v = 1'b0; p_v = 1'b0;
      m_err = 1'b0; m_cnt = 0;
    end else begin
      e2_v = p_v;
      if (p_v) e2_d = p_d;
      p_v = 1'b0;
      if (!csb1) begin
        if (addr1 < 7'd100) begin
          rd = m_mem[addr1];
`ifdef SRAM_RW_FORWARD_EN
          if (!csb0 && addr0 == addr1) rd = (rd & ~bm) | (din0 & bm);
`endif
        end else begin
          rd = 52'd0;
          m_err = 1'b1;
        end
        e1_v = 1'b1; e1_d = rd; p_v = 1'b1; p_d = rd;
      end else begin
        e1_v = 1'b0;
      end
      if (!csb0) begin
        if (addr0 < 7'd100) m_mem[addr0] = (m_mem[addr0] & ~bm) | (din0 & bm);
        else m_err = 1'b1;
      end
      if (!csb0 && !csb1 && addr0 == addr1 && addr0 < 7'd100 && m_cnt < 65535) m_cnt++;
    end
    @(posedge clk0);
    #1;
  endtask

  task automatic idle();
    csb0 = 1'b1; csb1 = 1'b1; wmask0 = 4'd0;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; idle(); addr0 = 7'd0; addr1 = 7'd0; din0 = 52'd0;
    tick(); tick();
    n_checks += 4;
    if (d1_dout !== 52'd0 || d2_dout !== 52'd0) begin n_fail++; $display("FAIL reset_dout got %h/%h want 0", d1_dout, d2_dout); end
    if (d1_valid !== 1'b0 || d2_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b/%b want 0", d1_valid, d2_valid); end
    if (d1_err !== 1'b0 || d2_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b/%b want 0", d1_err, d2_err); end
    if (d1_cnt !== 16'd0 || d2_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0", d1_cnt, d2_cnt); end
    rst0 = 1'b0;
  endtask

  task automatic init_mem();
    logic [63:0] r;
    for (int a = 0; a < 100; a++) begin
      r = {$urandom(), $urandom()};
      csb0 = 1'b0; wmask0 = 4'hF; addr0 = 7'(a); din0 = r[51:0];
      tick();
    end
    idle();
  endtask

  task automatic test_write_mask();
    logic [63:0] r;
    csb0 = 1'b0; wmask0 = 4'hF; addr0 = 7'd5; din0 = 52'd0; tick();
    wmask0 = 4'b0101; din0 = {52{1'b1}}; tick();
    csb0 = 1'b1; csb1 = 1'b0; addr1 = 7'd5; tick();
    n_checks += 2;
    if (d1_dout !== 52'h0007FFC001FFF) begin n_fail++; $display("FAIL mask_l1_dout got %h want %h", d1_dout, 52'h0007FFC001FFF); end
    if (d1_valid !== 1'b1 || d2_valid !== 1'b0) begin n_fail++; $display("FAIL mask_valid got %b/%b want 1/0", d1_valid, d2_valid); end
    idle(); tick();
    n_checks += 2;
    if (d2_dout !== 52'h0007FFC001FFF || d2_valid !== 1'b1) begin n_fail++; $display("FAIL mask_l2 got %h/%b want %h/1", d2_dout, d2_valid, 52'h0007FFC001FFF); end
    if (d1_valid !== 1'b0 || d1_dout !== 52'h0007FFC001FFF) begin n_fail++; $display("FAIL mask_l1_hold got %h/%b want held/0", d1_dout, d1_valid); end
    r = {$urandom(), $urandom()};
    csb0 = 1'b0; wmask0 = 4'd0; addr0 = 7'd6; din0 = r[51:0]; tick();
    csb0 = 1'b1; csb1 = 1'b0; addr1 = 7'd6; tick();
    n_checks++;
    if (d1_dout !== m_mem[6] || d1_dout !== e1_d) begin n_fail++; $display("FAIL mask_zero got %h want %h", d1_dout, m_mem[6]); end
    idle(); tick();
  endtask

  task automatic test_collision();
    logic [51:0] want;
    logic [63:0] r;
    rst0 = 1'b1; tick(); rst0 = 1'b0;
    csb0 = 1'b0; wmask0 = 4'hF; addr0 = 7'd9; din0 = 52'd0; tick();
    csb1 = 1'b0; addr1 = 7'd9; din0 = 52'hAAAAAAAAAAAAA; tick();
`ifdef SRAM_RW_FORWARD_EN
    want = 52'hAAAAAAAAAAAAA;
`else
    want = 52'd0;
`endif
    n_checks += 2;
    if (d1_cnt !== 16'd1 || d2_cnt !== 16'd1) begin n_fail++; $display("FAIL coll_cnt got %0d/%0d want 1", d1_cnt, d2_cnt); end
    if (d1_dout !== want) begin n_fail++; $display("FAIL coll_data got %h want %h", d1_dout, want); end
    csb0 = 1'b1; tick();
    n_checks += 2;
    if (d1_dout !== 52'hAAAAAAAAAAAAA) begin n_fail++; $display("FAIL coll_next_read got %h want %h", d1_dout, 52'hAAAAAAAAAAAAA); end
    if (d2_dout !== want) begin n_fail++; $display("FAIL coll_l2_data got %h want %h", d2_dout, want); end
    r = {$urandom(), $urandom()};
    csb0 = 1'b0; wmask0 = 4'b0110; din0 = r[51:0]; tick();
    n_checks += 2;
    if (d1_dout !== e1_d) begin n_fail++; $display("FAIL coll_partial got %h want %h", d1_dout, e1_d); end
    if (d1_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL coll_cnt2 got %0d want %0d", d1_cnt, m_cnt); end
    idle(); tick();
  endtask

  task automatic test_out_of_range();
    n_checks++;
    if (d1_err !== 1'b0) begin n_fail++; $display("FAIL oor_pre_err got %b want 0", d1_err); end
    csb0 = 1'b0; wmask0 = 4'hF; addr0 = 7'd120; din0 = 52'h1234567890ABC; tick();
    n_checks++;
    if (d1_err !== 1'b1 || d2_err !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err got %b/%b want 1", d1_err, d2_err); end
    csb0 = 1'b1; csb1 = 1'b0; addr1 = 7'd120; tick();
    n_checks++;
    if (d1_dout !== 52'd0 || d1_valid !== 1'b1) begin n_fail++; $display("FAIL oor_rd_l1 got %h/%b want 0/1", d1_dout, d1_valid); end
    idle(); tick();
    n_checks++;
    if (d2_dout !== 52'd0 || d2_valid !== 1'b1 || d1_err !== 1'b1) begin n_fail++; $display("FAIL oor_rd_l2 got %h/%b/%b want 0/1/1", d2_dout, d2_valid, d1_err); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] want_v;
    want_v = 5'b01110;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin csb1 = 1'b0; addr1 = 7'(k + 1); end
      else csb1 = 1'b1;
      tick();
      n_checks += 2;
      if (d2_valid !== want_v[k] || d2_valid !== e2_v) begin n_fail++; $display("FAIL b2b_valid edge %0d got %b want %b", k, d2_valid, want_v[k]); end
      if (want_v[k] && d2_dout !== m_mem[k]) begin n_fail++; $display("FAIL b2b_data edge %0d got %h want %h", k, d2_dout, m_mem[k]); end
    end
  endtask

  task automatic test_reset_in_flight();
    csb1 = 1'b0; addr1 = 7'd4; tick();
    rst0 = 1'b1; csb1 = 1'b1; tick();
    n_checks += 2;
    if (d2_valid !== 1'b0 || d2_dout !== 52'd0) begin n_fail++; $display("FAIL flush_l2 got %h/%b want 0/0", d2_dout, d2_valid); end
    if (d1_valid !== 1'b0 || d1_dout !== 52'd0 || d1_err !== 1'b0 || d1_cnt !== 16'd0) begin n_fail++; $display("FAIL flush_l1 got %h/%b/%b/%0d want zeros", d1_dout, d1_valid, d1_err, d1_cnt); end
    rst0 = 1'b0; tick();
    n_checks++;
    if (d2_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after got %b want 0", d2_valid); end
    csb1 = 1'b0; tick(); csb1 = 1'b1; tick();
    n_checks++;
    if (d2_dout !== m_mem[4] || d2_valid !== 1'b1) begin n_fail++; $display("FAIL flush_retained got %h want %h", d2_dout, m_mem[4]); end
  endtask

  task automatic test_random();
    logic [63:0] r;
    for (int c = 0; c < 400; c++) begin
      r = {$urandom(), $urandom()};
      csb0 = $urandom_range(0, 2) == 0; csb1 = $urandom_range(0, 2) == 0;
      wmask0 = 4'($urandom_range(0, 15)); din0 = r[51:0];
      addr0 = 7'($urandom_range(0, 109));
      addr1 = ($urandom_range(0, 3) == 0) ? addr0 : 7'($urandom_range(0, 109));
      if (c >= 300) begin csb0 = 1'b1; csb1 = 1'b0; addr1 = 7'(c - 300); end
      tick();
      n_checks += 4;
      if (d1_dout !== e1_d || d1_valid !== e1_v) begin n_fail++; $display("FAIL rand_l1 cyc %0d got %h/%b want %h/%b", c, d1_dout, d1_valid, e1_d, e1_v); end
      if (d2_dout !== e2_d || d2_valid !== e2_v) begin n_fail++; $display("FAIL rand_l2 cyc %0d got %h/%b want %h/%b", c, d2_dout, d2_valid, e2_d, e2_v); end
      if (d1_err !== m_err || d2_err !== m_err) begin n_fail++; $display("FAIL rand_err cyc %0d got %b/%b want %b", c, d1_err, d2_err, m_err); end
      if (d1_cnt !== 16'(m_cnt) || d2_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL rand_cnt cyc %0d got %0d/%0d want %0d", c, d1_cnt, d2_cnt, m_cnt); end
    end
    idle(); tick();
  endtask

  task automatic test_coll_saturation();
    rst0 = 1'b1; tick(); rst0 = 1'b0;
    csb0 = 1'b0; csb1 = 1'b0; wmask0 = 4'd0; addr0 = 7'd10; addr1 = 7'd10; din0 = 52'd0;
    for (int i = 0; i < 65540; i++) begin
      tick();
      if (i == 65533) begin
        n_checks++;
        if (d1_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre got %h want FFFE", d1_cnt); end
      end
    end
    n_checks += 2;
    if (d1_cnt !== 16'hFFFF || d2_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h/%h want FFFF", d1_cnt, d2_cnt); end
    if (d1_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL sat_model got %h want %h", d1_cnt, m_cnt); end
    idle(); tick();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    p_v = 1'b0; p_d = 52'd0;
    test_reset();
    init_mem();
    test_write_mask();
    test_collision();
    test_out_of_range();
    test_back_to_back();
    test_reset_in_flight();
    test_random();
    test_coll_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
